// File: rtl/matmul_operand_fetch_if.sv
// Operand-fetch bundle: consumer control, scratchpad read port and
// the operand stream back to the matmul calculation stage.
interface matmul_operand_fetch_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                  start_i;
    logic                  mode_i;
    logic                  get_matA_i;
    logic                  get_matB_i;
    logic                  get_matC_i;
    logic                  mem_rd_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [BUS_WIDTH-1:0]  mem_rdata_i;
    logic [BUS_WIDTH-1:0]  data_o;
    logic                  data_valid_o;
    logic                  finished_a_o;
    logic                  finished_b_o;
    logic                  finished_c_o;
    logic                  busy_o;

    modport master (
        output start_i, mode_i, get_matA_i, get_matB_i, get_matC_i,
        output mem_rdata_i,
        input  mem_rd_o, mem_addr_o, data_o, data_valid_o,
        input  finished_a_o, finished_b_o, finished_c_o, busy_o
    );

    modport slave (
        input  start_i, mode_i, get_matA_i, get_matB_i, get_matC_i,
        input  mem_rdata_i,
        output mem_rd_o, mem_addr_o, data_o, data_valid_o,
        output finished_a_o, finished_b_o, finished_c_o, busy_o
    );
endinterface

// File: rtl/matmul_operand_fetch.sv
// Operand loader: fetches A, B then C rows from the scratchpad and
// streams them to the matmul stage, one bus word per cycle.
module matmul_operand_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    matmul_operand_fetch_if.slave bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int IDX_W   = 2 * $clog2(MAX_DIM);
    localparam int N_C     = MAX_DIM * MAX_DIM;
    localparam int CNT_W   = $clog2(N_C + 1);

    localparam logic [4:0] CODE_A = 5'b00100;
    localparam logic [4:0] CODE_B = 5'b01000;
    localparam logic [4:0] CODE_C = 5'b10000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iss_q, iss_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             valid_q;
    logic             zero_q;
    logic             mode_q;
    logic             fin_a_q, fin_b_q, fin_c_q;

    logic             fetching;
    logic             get;
    logic [4:0]       code;
    logic [CNT_W-1:0] n_beats;
    logic             issue;
    logic             zero_beat;
    logic             last_beat;
    logic             rd;

    always_comb begin
        fetching = 1'b0;
        get      = 1'b0;
        code     = '0;
        n_beats  = '0;
        unique case (state_q)
            FETCH_A: begin
                fetching = 1'b1;
                get      = bus.get_matA_i;
                code     = CODE_A;
                n_beats  = CNT_W'(MAX_DIM);
            end
            FETCH_B: begin
                fetching = 1'b1;
                get      = bus.get_matB_i;
                code     = CODE_B;
                n_beats  = CNT_W'(MAX_DIM);
            end
            FETCH_C: begin
                fetching = 1'b1;
                get      = bus.get_matC_i;
                code     = CODE_C;
                n_beats  = CNT_W'(N_C);
            end
            default: ;
        endcase
        issue     = fetching && get && (iss_q < n_beats);
        zero_beat = (state_q == FETCH_C) && !mode_q;
        last_beat = fetching && valid_q && (ret_q == n_beats - CNT_W'(1));
        rd        = issue && !zero_beat;
    end

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        ret_d   = ret_q;
        if (issue)   iss_d = iss_q + CNT_W'(1);
        if (valid_q) ret_d = ret_q + CNT_W'(1);
        unique case (state_q)
            IDLE:    if (bus.start_i) state_d = FETCH_A;
            FETCH_A: if (last_beat)   state_d = FETCH_B;
            FETCH_B: if (last_beat)   state_d = FETCH_C;
            FETCH_C: if (last_beat)   state_d = DONE;
            default: ;
        endcase
        if (last_beat) begin
            iss_d = '0;
            ret_d = '0;
        end
        // Dropping start aborts from any state, in-flight return included
        if (!bus.start_i) begin
            state_d = IDLE;
            iss_d   = '0;
            ret_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            iss_q   <= '0;
            ret_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            mode_q  <= 1'b0;
            fin_a_q <= 1'b0;
            fin_b_q <= 1'b0;
            fin_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            if (!bus.start_i) begin
                valid_q <= 1'b0;
                zero_q  <= 1'b0;
                mode_q  <= 1'b0;
                fin_a_q <= 1'b0;
                fin_b_q <= 1'b0;
                fin_c_q <= 1'b0;
            end else begin
                valid_q <= issue;
                zero_q  <= issue && zero_beat;
                if (state_q == FETCH_B && last_beat) mode_q  <= bus.mode_i;
                if (state_q == FETCH_A && last_beat) fin_a_q <= 1'b1;
                if (state_q == FETCH_B && last_beat) fin_b_q <= 1'b1;
                if (state_q == FETCH_C && last_beat) fin_c_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_addr_o = '0;
        if (rd) begin
            bus.mem_addr_o[4:0]         = code;
            bus.mem_addr_o[5 +: IDX_W]  = iss_q[IDX_W-1:0];
        end
    end

    assign bus.mem_rd_o     = rd;
    assign bus.data_valid_o = valid_q;
    assign bus.data_o       = (valid_q && !zero_q) ? bus.mem_rdata_i : '0;
    assign bus.finished_a_o = fin_a_q;
    assign bus.finished_b_o = fin_b_q;
    assign bus.finished_c_o = fin_c_q;
    assign bus.busy_o       = fetching;
endmodule

// File: tb/tb_matmul_operand_fetch.sv
// Directed vector bench for matmul_operand_fetch with a
// 1-cycle scratchpad model returning address-derived words.
module tb_matmul_operand_fetch;
    logic clk;
    logic rst_ni;
    int   total;
    int   bad;

    matmul_operand_fetch_if #(.BUS_WIDTH(16), .ADDR_WIDTH(32)) bus ();

    matmul_operand_fetch #(
        .DATA_WIDTH(8),
        .BUS_WIDTH (16),
        .ADDR_WIDTH(32)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] f(input logic [31:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    always @(posedge clk)
        bus.mem_rdata_i <= bus.mem_rd_o ? f(bus.mem_addr_o) : 16'hDEAD;

    typedef struct {
        int          tid;
        logic        st, md, ga, gb, gc;
        logic        rd;
        logic [31:0] addr;
        logic        vld;
        logic [15:0] data;
        logic        fa, fb, fc, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input int tid,
        input logic st, md, ga, gb, gc,
        input logic rd, input logic [31:0] addr,
        input logic vld, input logic [15:0] data,
        input logic fa, fb, fc, busy
    );
        vec_t v;
        v.tid = tid; v.st = st; v.md = md;
        v.ga = ga; v.gb = gb; v.gc = gc;
        v.rd = rd; v.addr = addr; v.vld = vld; v.data = data;
        v.fa = fa; v.fb = fb; v.fc = fc; v.busy = busy;
        return v;
    endfunction

    task automatic add(
        input int tid,
        input logic st, md, ga, gb, gc,
        input logic rd, input logic [31:0] addr,
        input logic vld, input logic [15:0] data,
        input logic fa, fb, fc, busy
    );
        tbl.push_back(mk(tid, st, md, ga, gb, gc, rd, addr, vld, data,
                         fa, fb, fc, busy));
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, " rd"},   32'(bus.mem_rd_o),     32'(v.rd));
        chk({tag, " addr"}, bus.mem_addr_o,        v.addr);
        chk({tag, " vld"},  32'(bus.data_valid_o), 32'(v.vld));
        chk({tag, " data"}, 32'(bus.data_o),       32'(v.data));
        chk({tag, " fa"},   32'(bus.finished_a_o), 32'(v.fa));
        chk({tag, " fb"},   32'(bus.finished_b_o), 32'(v.fb));
        chk({tag, " fc"},   32'(bus.finished_c_o), 32'(v.fc));
        chk({tag, " busy"}, 32'(bus.busy_o),       32'(v.busy));
    endtask

    task automatic drive(input vec_t v);
        bus.start_i    = v.st;
        bus.mode_i     = v.md;
        bus.get_matA_i = v.ga;
        bus.get_matB_i = v.gb;
        bus.get_matC_i = v.gc;
    endtask

    task automatic cyc(input vec_t v, input int row);
        drive(v);
        #1;
        chk_out($sformatf("t%0d.%0d", v.tid, row), v);
        @(posedge clk);
        #1;
    endtask

    vec_t zero_v;

    initial begin
        total = 0;
        bad   = 0;
        zero_v = mk(0, 0,0,0,0,0, 0,0, 0,0, 0,0,0,0);

        // test 1: mode=1, full fetch
        add(1, 1,1,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        add(1, 1,1,1,0,0, 1,'h04, 0,0,                 0,0,0,1);
        add(1, 1,1,1,0,0, 1,'h24, 1,f('h04),           0,0,0,1);
        add(1, 1,1,1,0,0, 0,'h00, 1,f('h24),           0,0,0,1);
        add(1, 1,1,0,1,0, 1,'h08, 0,0,                 1,0,0,1);
        add(1, 1,1,0,1,0, 1,'h28, 1,f('h08),           1,0,0,1);
        add(1, 1,1,0,1,0, 0,'h00, 1,f('h28),           1,0,0,1);
        add(1, 1,1,0,0,1, 1,'h10, 0,0,                 1,1,0,1);
        add(1, 1,1,0,0,1, 1,'h30, 1,f('h10),           1,1,0,1);
        add(1, 1,1,0,0,1, 1,'h50, 1,f('h30),           1,1,0,1);
        add(1, 1,1,0,0,1, 1,'h70, 1,f('h50),           1,1,0,1);
        add(1, 1,1,0,0,1, 0,'h00, 1,f('h70),           1,1,0,1);
        add(1, 1,1,0,0,1, 0,'h00, 0,0,                 1,1,1,0);
        add(1, 0,1,0,0,0, 0,'h00, 0,0,                 1,1,1,0);
        add(1, 0,1,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        // test 2: mode=0 zero bias, mode flips mid-C, C paced
        add(2, 1,0,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        add(2, 1,0,1,0,0, 1,'h04, 0,0,                 0,0,0,1);
        add(2, 1,0,1,0,0, 1,'h24, 1,f('h04),           0,0,0,1);
        add(2, 1,0,1,0,0, 0,'h00, 1,f('h24),           0,0,0,1);
        add(2, 1,0,0,1,0, 1,'h08, 0,0,                 1,0,0,1);
        add(2, 1,0,0,1,0, 1,'h28, 1,f('h08),           1,0,0,1);
        add(2, 1,0,0,1,0, 0,'h00, 1,f('h28),           1,0,0,1);
        add(2, 1,0,0,0,1, 0,'h00, 0,0,                 1,1,0,1);
        add(2, 1,1,0,0,1, 0,'h00, 1,0,                 1,1,0,1);
        add(2, 1,1,0,0,0, 0,'h00, 1,0,                 1,1,0,1);
        add(2, 1,1,0,0,1, 0,'h00, 0,0,                 1,1,0,1);
        add(2, 1,1,0,0,1, 0,'h00, 1,0,                 1,1,0,1);
        add(2, 1,1,0,0,1, 0,'h00, 1,0,                 1,1,0,1);
        add(2, 1,1,0,0,1, 0,'h00, 0,0,                 1,1,1,0);
        add(2, 0,0,0,0,0, 0,'h00, 0,0,                 1,1,1,0);
        add(2, 0,0,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        // test 3: get_matA stalls
        add(3, 1,1,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        add(3, 1,1,1,0,0, 1,'h04, 0,0,                 0,0,0,1);
        add(3, 1,1,0,0,0, 0,'h00, 1,f('h04),           0,0,0,1);
        add(3, 1,1,0,0,0, 0,'h00, 0,0,                 0,0,0,1);
        add(3, 1,1,1,0,0, 1,'h24, 0,0,                 0,0,0,1);
        add(3, 1,1,0,0,0, 0,'h00, 1,f('h24),           0,0,0,1);
        add(3, 1,1,0,0,0, 0,'h00, 0,0,                 1,0,0,1);
        add(3, 0,1,0,0,0, 0,'h00, 0,0,                 1,0,0,1);
        add(3, 0,1,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        // test 6: wrong-phase requests ignored
        add(6, 1,1,0,0,0, 0,'h00, 0,0,                 0,0,0,0);
        add(6, 1,1,1,1,1, 1,'h04, 0,0,                 0,0,0,1);
        add(6, 1,1,1,1,1, 1,'h24, 1,f('h04),           0,0,0,1);
        add(6, 1,1,1,1,1, 0,'h00, 1,f('h24),           0,0,0,1);
        add(6, 1,1,1,0,1, 0,'h00, 0,0,                 1,0,0,1);
        add(6, 0,1,0,0,0, 0,'h00, 0,0,                 1,0,0,1);
        add(6, 0,1,0,0,0, 0,'h00, 0,0,                 0,0,0,0);

        rst_ni = 1'b0;
        drive(zero_v);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", zero_v);
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i], i);

        // test 4: start dropped while first B read is issued
        cyc(mk(4, 1,1,0,0,0, 0,'h00, 0,0,       0,0,0,0), 0);
        cyc(mk(4, 1,1,1,0,0, 1,'h04, 0,0,       0,0,0,1), 1);
        cyc(mk(4, 1,1,1,0,0, 1,'h24, 1,f('h04), 0,0,0,1), 2);
        cyc(mk(4, 1,1,0,0,0, 0,'h00, 1,f('h24), 0,0,0,1), 3);
        cyc(mk(4, 0,1,0,1,0, 1,'h08, 0,0,       1,0,0,1), 4);
        cyc(mk(4, 0,1,0,1,0, 0,'h00, 0,0,       0,0,0,0), 5);
        cyc(mk(4, 1,1,0,0,0, 0,'h00, 0,0,       0,0,0,0), 6);
        cyc(mk(4, 1,1,1,0,0, 1,'h04, 0,0,       0,0,0,1), 7);
        cyc(mk(4, 0,1,0,0,0, 0,'h00, 1,f('h04), 0,0,0,1), 8);
        cyc(mk(4, 0,1,0,0,0, 0,'h00, 0,0,       0,0,0,0), 9);

        // test 5: async reset in the C phase
        for (int i = 0; i < 9; i++)
            cyc(tbl[i], 100 + i);
        drive(mk(5, 1,1,0,0,1, 0,0, 0,0, 0,0,0,0));
        #2;
        rst_ni = 1'b0;
        #1;
        chk_out("t5.async", zero_v);
        @(posedge clk);
        #1;
        chk_out("t5.held", zero_v);
        rst_ni = 1'b1;
        cyc(mk(5, 1,1,0,0,0, 0,'h00, 0,0,       0,0,0,0), 1);
        cyc(mk(5, 1,1,1,0,0, 1,'h04, 0,0,       0,0,0,1), 2);
        cyc(mk(5, 1,1,1,0,0, 1,'h24, 1,f('h04), 0,0,0,1), 3);
        cyc(mk(5, 0,1,0,0,0, 0,'h00, 1,f('h24), 0,0,0,1), 4);
        cyc(mk(5, 0,1,0,0,0, 0,'h00, 0,0,       0,0,0,0), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
